datapath_trace_monitor: RTL and testbench

- Synthesizable run monitor that sits beside the single-cycle datapath core and samples its `result` and `pc` outputs every clock.
- Stores the samples in a circular trace buffer and counts cycles.
- Detects program halt (PC stuck) or a cycle budget expiring.
- Exposes a random-access readout port so benches and debug logic can inspect execution history instead of relying on per-cycle console prints.

---
 rtl/datapath_trace_monitor_pkg.sv | 20 ++
 rtl/datapath_trace_monitor_trace_ram.sv | 30 +++
 rtl/datapath_trace_monitor.sv | 150 +++++++++++++++
 tb/tb_datapath_trace_monitor.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_trace_monitor_pkg.sv
// Shared types for the datapath trace monitor: FSM state encoding and the
// packed trace entry layout {pc, result} at the default core widths.
package datapath_trace_monitor_pkg;

  localparam int unsigned TRACE_DATA_W = 32;
  localparam int unsigned TRACE_PC_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [TRACE_PC_W-1:0]   pc;
    logic [TRACE_DATA_W-1:0] result;
  } trace_entry_t;

endpackage

// File: rtl/datapath_trace_monitor_trace_ram.sv
// DEPTH x W single-write / single-read synchronous RAM, read-before-write.
// The read register returns zero on any cycle the read is not enabled.
module trace_ram #(
  parameter int unsigned W     = 40,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking read of the same slot sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
    else         rdata <= '0;
  end

endmodule

// File: rtl/datapath_trace_monitor.sv
// Run monitor beside the datapath core: circular trace of {pc, result},
// cycle budget, PC-stall halt detection and a random-access readout port.
// Optional macro TRACE_CHANGE_ONLY_EN: store only samples whose pc changed.
module datapath_trace_monitor
  import datapath_trace_monitor_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PC_W        = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned MAX_CYCLES  = 24,
  parameter int unsigned HALT_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DATA_W-1:0]        result,
  input  logic [PC_W-1:0]          pc,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_result,
  output logic [PC_W-1:0]          rd_pc,
  output logic                     rd_valid,
  output logic [1:0]               state,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [$clog2(DEPTH):0]   entry_count,
  output logic                     wrapped,
  output logic                     halted,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = PC_W + DATA_W;

  state_t          state_q;
  state_t          state_nx;
  logic [AW-1:0]   wr_ptr;
  logic [PC_W-1:0] prev_pc;
  logic            first_q;
  logic [CNT_W-1:0] stall_q;

  logic             launch;
  logic             capture;
  logic             write;
  logic             same_pc;
  logic [CNT_W-1:0] cycle_nx;
  logic [CNT_W-1:0] stall_nx;

  logic [AW-1:0] rd_idx;
  logic          rd_ok;
  logic [EW-1:0] rd_data;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nx;
  end

  // Next state plus per-cycle capture/launch controls; halt outranks budget.
  always_comb begin
    state_nx = state_q;
    launch   = 1'b0;
    capture  = 1'b0;
    write    = 1'b0;
    same_pc  = !first_q && (pc == prev_pc);
    cycle_nx = cycle_count + CNT_W'(1);
    stall_nx = same_pc ? (stall_q + CNT_W'(1)) : '0;
    case (state_q)
      RUN: begin
        capture = 1'b1;
`ifdef TRACE_CHANGE_ONLY_EN
        write = !same_pc;
`else
        write = 1'b1;
`endif
        if (stall_nx == CNT_W'(HALT_CYCLES))     state_nx = HALT;
        else if (cycle_nx == CNT_W'(MAX_CYCLES)) state_nx = DONE;
      end
      default: begin
        if (start) begin
          launch   = 1'b1;
          state_nx = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      entry_count <= '0;
      wrapped     <= 1'b0;
      cycle_count <= '0;
      stall_q     <= '0;
      prev_pc     <= '0;
      first_q     <= 1'b1;
      halted      <= 1'b0;
      done        <= 1'b0;
    end else if (launch) begin
      wr_ptr      <= '0;
      entry_count <= '0;
      wrapped     <= 1'b0;
      cycle_count <= '0;
      stall_q     <= '0;
      first_q     <= 1'b1;
      halted      <= 1'b0;
      done        <= 1'b0;
    end else if (capture) begin
      cycle_count <= cycle_nx;
      stall_q     <= stall_nx;
      prev_pc     <= pc;
      first_q     <= 1'b0;
      if (write) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (entry_count == CW'(DEPTH)) wrapped <= 1'b1;
        else                           entry_count <= entry_count + CW'(1);
      end
      if (state_nx == HALT) halted <= 1'b1;
      if (state_nx == DONE) done   <= 1'b1;
    end
  end

  // Readout addresses are relative to the oldest surviving entry.
  assign rd_idx = (wrapped ? wr_ptr : AW'(0)) + rd_addr;
  assign rd_ok  = rd_en && ({1'b0, rd_addr} < entry_count);

  always_ff @(posedge clk) begin
    if (reset) rd_valid <= 1'b0;
    else       rd_valid <= rd_ok;
  end

  trace_ram #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_trace_ram (
    .clk   (clk),
    .reset (reset),
    .we    (write),
    .waddr (wr_ptr),
    .wdata ({pc, result}),
    .re    (rd_ok),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  assign rd_pc     = rd_data[EW-1:DATA_W];
  assign rd_result = rd_data[DATA_W-1:0];
  assign state     = state_q;

endmodule

// File: tb/tb_datapath_trace_monitor.sv
// Scoreboard bench for datapath_trace_monitor: stimulus queues expectations
// tagged with the clock edge after which they must hold; a monitor checks them.
module tb_datapath_trace_monitor;
  import datapath_trace_monitor_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] result;
  logic [7:0]  pc;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_result;
  logic [7:0]  rd_pc;
  logic        rd_valid;
  logic [1:0]  state;
  logic [15:0] cycle_count;
  logic [4:0]  entry_count;
  logic        wrapped;
  logic        halted;
  logic        done;

`ifdef TRACE_CHANGE_ONLY_EN
  localparam bit CO = 1'b1;
`else
  localparam bit CO = 1'b0;
`endif

  localparam int unsigned WATCHDOG_CYCLES = 2000;

  datapath_trace_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .result      (result),
    .pc          (pc),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_result   (rd_result),
    .rd_pc       (rd_pc),
    .rd_valid    (rd_valid),
    .state       (state),
    .cycle_count (cycle_count),
    .entry_count (entry_count),
    .wrapped     (wrapped),
    .halted      (halted),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int unsigned sel;
    logic [63:0] val;
    int unsigned tag;
  } exp_t;

  exp_t        expq[$];
  int unsigned cyc_n   = 0;
  int unsigned test_id = 0;
  int unsigned checks  = 0;
  int unsigned errors  = 0;
  bit          finished = 1'b0;

  function automatic string sel_name(int unsigned sel);
    case (sel)
      0:       return "state";
      1:       return "cycle_count";
      2:       return "entry_count";
      3:       return "wrapped";
      4:       return "halted";
      5:       return "done";
      default: return "readout{valid,pc,result}";
    endcase
  endfunction

  function automatic logic [63:0] observe(int unsigned sel);
    case (sel)
      0:       return 64'(state);
      1:       return 64'(cycle_count);
      2:       return 64'(entry_count);
      3:       return 64'(wrapped);
      4:       return 64'(halted);
      5:       return 64'(done);
      default: return 64'({rd_valid, rd_pc, rd_result});
    endcase
  endfunction

  // Monitor: after each rising edge, compare every expectation due at it.
  always @(posedge clk) begin
    exp_t        e;
    logic [63:0] act;
    cyc_n = cyc_n + 1;
    #1;
    while (expq.size() != 0 && expq[0].cyc <= cyc_n) begin
      e   = expq.pop_front();
      act = observe(e.sel);
      checks = checks + 1;
      if (e.cyc != cyc_n || act !== e.val) begin
        errors = errors + 1;
        $display("FAIL t%0d %s: got %0h required %0h (edge %0d/%0d)",
                 e.tag, sel_name(e.sel), act, e.val, cyc_n, e.cyc);
      end
    end
  end

  // Watchdog: the stimulus must complete within a bounded number of cycles.
  initial begin
    repeat (WATCHDOG_CYCLES) @(posedge clk);
    if (!finished) begin
      errors = errors + 1;
      $display("FAIL watchdog: stimulus still running after %0d cycles (t%0d)",
               WATCHDOG_CYCLES, test_id);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic expect_val(int unsigned sel, logic [63:0] val);
    exp_t e;
    e.cyc = cyc_n + 1;
    e.sel = sel;
    e.val = val;
    e.tag = test_id;
    expq.push_back(e);
  endtask

  task automatic expect_status(logic [1:0] st, int unsigned cc, int unsigned ec,
                               bit wr, bit hl, bit dn);
    expect_val(0, 64'(st));
    expect_val(1, 64'(cc));
    expect_val(2, 64'(ec));
    expect_val(3, 64'(wr));
    expect_val(4, 64'(hl));
    expect_val(5, 64'(dn));
  endtask

  task automatic expect_read(bit v, logic [7:0] p, logic [31:0] r);
    trace_entry_t te;
    te.pc     = p;
    te.result = r;
    expect_val(6, 64'({v, te}));
  endtask

  // Issue a readout request this cycle; data is due after the next edge.
  task automatic rd(logic [3:0] a, bit v, logic [7:0] p, logic [31:0] r);
    rd_en   = 1'b1;
    rd_addr = a;
    expect_read(v, p, r);
  endtask

  task automatic launch_run();
    start = 1'b1;
    expect_status(2'(RUN), 0, 0, 1'b0, 1'b0, 1'b0);
    cyc();
    start = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    result  = '0;
    pc      = '0;
    rd_en   = 1'b0;
    rd_addr = '0;
    cyc();

    // Reset values
    test_id = 0;
    expect_status(2'(IDLE), 0, 0, 1'b0, 1'b0, 1'b0);
    expect_read(1'b0, 8'd0, 32'd0);
    cyc();
    checks = checks + 1;
    if (state !== 2'd0 || cycle_count !== 16'd0 || entry_count !== 5'd0 ||
        wrapped !== 1'b0 || halted !== 1'b0 || done !== 1'b0 ||
        rd_valid !== 1'b0 || rd_pc !== 8'd0 || rd_result !== 32'd0) begin
      errors = errors + 1;
      $display("FAIL reset state: state=%0d cc=%0d ec=%0d wr=%0b hl=%0b dn=%0b rv=%0b",
               state, cycle_count, entry_count, wrapped, halted, done, rd_valid);
    end
    reset = 1'b0;

    // Ramp to budget expiry with wrap
    test_id = 1;
    launch_run();
    for (int i = 0; i < 24; i++) begin
      pc     = 8'(i);
      result = 32'(3 * i);
      if (i == 23) expect_status(2'(DONE), 24, 16, 1'b1, 1'b0, 1'b1);
      cyc();
    end
    pc = 8'd200;
    rd(4'd0, 1'b1, 8'd8, 32'd24);
    cyc();
    rd(4'd15, 1'b1, 8'd23, 32'd69);
    cyc();
    rd(4'd7, 1'b1, 8'd15, 32'd45);
    expect_status(2'(DONE), 24, 16, 1'b1, 1'b0, 1'b1);
    cyc();
    rd_en = 1'b0;
    expect_read(1'b0, 8'd0, 32'd0);
    cyc();

    // Halt on repeated PC; restart from DONE overwrites from index 0
    test_id = 2;
    launch_run();
    for (int i = 0; i < 8; i++) begin
      pc     = (i < 3) ? 8'(i) : 8'd3;
      result = 32'(100 + i);
      if (i == 7) expect_status(2'(HALT), 8, CO ? 4 : 8, 1'b0, 1'b1, 1'b0);
      cyc();
    end
    rd(4'd0, 1'b1, 8'd0, 32'd100);
    cyc();
    rd(4'd3, 1'b1, 8'd3, 32'd103);
    cyc();
    rd(4'd8, 1'b0, 8'd0, 32'd0);
    cyc();
    rd_en = 1'b0;

    // Reads during a run at the entry_count boundary; start ignored in RUN
    test_id = 3;
    launch_run();
    for (int i = 0; i < 24; i++) begin
      pc     = 8'(i);
      result = 32'h0000_A000 + 32'(i);
      start  = (i == 5);
      if (i == 6) expect_val(1, 64'd7);
      if (i == 10)      rd(4'd10, 1'b0, 8'd0, 32'd0);
      else if (i == 11) rd(4'd9, 1'b1, 8'd9, 32'h0000_A009);
      else              rd_en = 1'b0;
      if (i == 23) expect_status(2'(DONE), 24, 16, 1'b1, 1'b0, 1'b1);
      cyc();
    end
    start = 1'b0;

    // Reset mid-run aborts; relaunch starts clean
    test_id = 4;
    launch_run();
    for (int i = 0; i < 6; i++) begin
      pc     = 8'(50 + i);
      result = 32'(i);
      if (i == 5) begin
        reset = 1'b1;
        expect_status(2'(IDLE), 0, 0, 1'b0, 1'b0, 1'b0);
        expect_read(1'b0, 8'd0, 32'd0);
      end
      cyc();
    end
    reset = 1'b0;
    launch_run();
    for (int i = 0; i < 3; i++) begin
      pc     = 8'(40 + i);
      result = 32'h400 + 32'(i);
      if (i == 2) expect_status(2'(RUN), 3, 3, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    for (int j = 0; j < 4; j++) begin
      if (j == 0) rd(4'd0, 1'b1, 8'd40, 32'h400);
      else        rd_en = 1'b0;
      if (j == 3) expect_status(2'(HALT), 7, CO ? 3 : 7, 1'b0, 1'b1, 1'b0);
      cyc();
    end

    // Halt and budget on the same cycle: halt wins
    test_id = 5;
    launch_run();
    for (int i = 0; i < 24; i++) begin
      pc     = (i < 19) ? 8'(i) : 8'd19;
      result = 32'(i);
      if (i == 23) begin
        expect_val(0, 64'(HALT));
        expect_val(1, 64'd24);
        expect_val(4, 64'd1);
        expect_val(5, 64'd0);
      end
      cyc();
    end

`ifdef TRACE_CHANGE_ONLY_EN
    // Only PC changes consume buffer space
    test_id = 6;
    launch_run();
    for (int i = 0; i < 9; i++) begin
      pc     = (i == 0) ? 8'd0 : (i < 4) ? 8'd1 : 8'd2;
      result = 32'h600 + 32'(i);
      if (i == 4) begin
        expect_val(1, 64'd5);
        expect_val(2, 64'd3);
      end
      if (i == 8) expect_status(2'(HALT), 9, 3, 1'b0, 1'b1, 1'b0);
      cyc();
    end
    rd(4'd0, 1'b1, 8'd0, 32'h600);
    cyc();
    rd(4'd1, 1'b1, 8'd1, 32'h601);
    cyc();
    rd(4'd2, 1'b1, 8'd2, 32'h604);
    cyc();
    rd(4'd3, 1'b0, 8'd0, 32'd0);
    cyc();
`endif

    rd_en = 1'b0;
    cyc();
    cyc();
    cyc();
    checks = checks + 1;
    if (expq.size() != 0) begin
      errors = errors + 1;
      $display("FAIL expired wait: %0d expectation(s) never checked, first due at edge %0d (t%0d)",
               expq.size(), expq[0].cyc, expq[0].tag);
    end
    finished = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
